line_replay_fifo: RTL and testbench

Single-clock, parametrised FIFO for the BOB line-buffer path; successor to the dual-clock Gray-pointer FIFO for cases where producer and consumer share one clock. Adds:
- occupancy output and almost-full/almost-empty thresholds;
- selectable standard or first-word-fall-through (FWFT) read mode;
- mark/rewind line replay, so a stored video line can be re-read for bob line doubling without re-writing it.

---
 rtl/line_replay_fifo_pkg.sv | 18 +
 rtl/line_replay_fifo_sdp_ram.sv | 30 +++
 rtl/line_replay_fifo.sv | 150 +++++++++++++++
 tb/tb_line_replay_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_replay_fifo_pkg.sv
// Shared definitions for the line replay FIFO: pointer width, FWFT output-stage
// state encoding and default flag thresholds.
package line_fifo_pkg;

  localparam int unsigned AFULL_MARGIN   = 4;
  localparam int unsigned AEMPTY_DEFAULT = 4;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_FETCH = 2'd1,
    STG_VALID = 2'd2
  } stage_t;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/line_replay_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the storage array is not.
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_replay_fifo.sv
// Single-clock line-buffer FIFO with occupancy flags, optional FWFT read mode
// and mark/rewind replay of a stored line.
module line_replay_fifo
  import line_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned FWFT         = 0,
  parameter int unsigned REPLAY_EN    = 1,
  parameter int unsigned AFULL_LEVEL  = (1 << ADDR_WIDTH) - AFULL_MARGIN,
  parameter int unsigned AEMPTY_LEVEL = AEMPTY_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDR_WIDTH:0]      level,
  input  logic                     mark,
  input  logic                     rewind,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned   PW       = ptr_width(ADDR_WIDTH);
  localparam int unsigned   DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [PW-1:0]         wr_ptr, rd_ptr, mark_reg, mark_ptr, prot_cnt, rd_ptr_nxt;
  logic                  rewind_act, mark_act;
  logic                  wr_acc, wr_err, rd_acc, rd_err;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;

  assign mark_ptr     = (REPLAY_EN != 0) ? mark_reg : rd_ptr;
  assign level        = wr_ptr - rd_ptr;
  assign prot_cnt     = wr_ptr - mark_ptr;
  assign full         = (prot_cnt == DEPTH_P);
  assign almost_full  = (prot_cnt >= AFULL_P);
  assign almost_empty = (level <= AEMPTY_P);

  assign rewind_act = rewind && (REPLAY_EN != 0);
  assign mark_act   = mark && !rewind_act && (REPLAY_EN != 0);
  assign wr_acc     = wr_en && !full;
  assign wr_err     = wr_en && full;
  assign rd_acc     = rd_en && !rewind_act && !empty;
  assign rd_err     = rd_en && !rewind_act && empty;
  assign rd_ptr_nxt = rd_ptr + PW'(rd_acc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mark_reg  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rewind_act) rd_ptr <= mark_ptr;
      else            rd_ptr <= rd_ptr_nxt;
      if (mark_act) mark_reg <= rd_ptr_nxt;
      if (wr_err)       overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (rd_err)       underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_acc),
    .waddr  (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata  (wr_data),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    stage_t        stage, stage_nxt;
    logic [PW-1:0] fetch_ptr;
    logic          more;

    assign more      = (fetch_ptr != wr_ptr);
    assign rd_valid  = (stage == STG_VALID);
    assign empty     = !rd_valid;
    assign ram_raddr = fetch_ptr[ADDR_WIDTH-1:0];

    // A pop with more data re-reads RAM in the same cycle so the stage stays
    // VALID (no bubble); FETCH is only the wait state when refilling from EMPTY.
    always_comb begin
      stage_nxt = stage;
      ram_re    = 1'b0;
      case (stage)
        STG_EMPTY: if (more) stage_nxt = STG_FETCH;
        STG_FETCH: begin
          ram_re    = 1'b1;
          stage_nxt = STG_VALID;
        end
        STG_VALID: if (rd_acc) begin
          if (more) ram_re    = 1'b1;
          else      stage_nxt = STG_EMPTY;
        end
        default: stage_nxt = STG_EMPTY;
      endcase
      if (rewind_act) begin
        stage_nxt = STG_EMPTY;
        ram_re    = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        stage     <= STG_EMPTY;
        fetch_ptr <= '0;
      end else begin
        stage <= stage_nxt;
        if (rewind_act)  fetch_ptr <= mark_ptr;
        else if (ram_re) fetch_ptr <= fetch_ptr + ONE;
      end
    end
  end else begin : g_std
    logic valid_q;

    assign empty     = (level == '0);
    assign ram_re    = rd_acc;
    assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
    assign rd_valid  = valid_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) valid_q <= 1'b0;
      else         valid_q <= rd_acc;
    end
  end

endmodule

// File: tb/tb_line_replay_fifo.sv
// Directed bench: instance a is standard-read with replay, instance b is FWFT with replay.
module tb_line_replay_fifo;

  localparam logic [4:0] W  = 5'b00001;
  localparam logic [4:0] R  = 5'b00010;
  localparam logic [4:0] M  = 5'b00100;
  localparam logic [4:0] RW = 5'b01000;
  localparam logic [4:0] CL = 5'b10000;
  localparam logic [4:0] NOP = 5'b00000;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic       a_wr = 1'b0, a_rd = 1'b0, a_mk = 1'b0, a_rw = 1'b0, a_cl = 1'b0;
  logic [7:0] a_wd = 8'h00;
  logic       a_full, a_af, a_rv, a_empty, a_ae, a_ovf, a_udf;
  logic [7:0] a_rdata;
  logic [4:0] a_level;

  logic       b_wr = 1'b0, b_rd = 1'b0, b_mk = 1'b0, b_rw = 1'b0, b_cl = 1'b0;
  logic [7:0] b_wd = 8'h00;
  logic       b_full, b_af, b_rv, b_empty, b_ae, b_ovf, b_udf;
  logic [7:0] b_rdata;
  logic [4:0] b_level;

  int checks = 0;
  int errors = 0;

  line_replay_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .REPLAY_EN(1)) dut_a (
    .clk(clk), .resetn(resetn), .wr_en(a_wr), .wr_data(a_wd), .full(a_full),
    .almost_full(a_af), .rd_en(a_rd), .rd_data(a_rdata), .rd_valid(a_rv),
    .empty(a_empty), .almost_empty(a_ae), .level(a_level), .mark(a_mk),
    .rewind(a_rw), .overflow(a_ovf), .underflow(a_udf), .clr_err(a_cl)
  );

  line_replay_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .REPLAY_EN(1)) dut_b (
    .clk(clk), .resetn(resetn), .wr_en(b_wr), .wr_data(b_wd), .full(b_full),
    .almost_full(b_af), .rd_en(b_rd), .rd_data(b_rdata), .rd_valid(b_rv),
    .empty(b_empty), .almost_empty(b_ae), .level(b_level), .mark(b_mk),
    .rewind(b_rw), .overflow(b_ovf), .underflow(b_udf), .clr_err(b_cl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_op(input logic [7:0] wd, input logic [4:0] ctl);
    a_wd = wd; a_wr = ctl[0]; a_rd = ctl[1]; a_mk = ctl[2]; a_rw = ctl[3]; a_cl = ctl[4];
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0; a_mk = 1'b0; a_rw = 1'b0; a_cl = 1'b0;
  endtask

  task automatic b_op(input logic [7:0] wd, input logic [4:0] ctl);
    b_wd = wd; b_wr = ctl[0]; b_rd = ctl[1]; b_mk = ctl[2]; b_rw = ctl[3]; b_cl = ctl[4];
    @(posedge clk); #1;
    b_wr = 1'b0; b_rd = 1'b0; b_mk = 1'b0; b_rw = 1'b0; b_cl = 1'b0;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_a_full"},   32'(a_full),   0);
    chk({t, "_a_afull"},  32'(a_af),     0);
    chk({t, "_a_empty"},  32'(a_empty),  1);
    chk({t, "_a_aempty"}, 32'(a_ae),     1);
    chk({t, "_a_level"},  32'(a_level),  0);
    chk({t, "_a_rdata"},  32'(a_rdata),  0);
    chk({t, "_a_rvalid"}, 32'(a_rv),     0);
    chk({t, "_a_ovf"},    32'(a_ovf),    0);
    chk({t, "_a_udf"},    32'(a_udf),    0);
    chk({t, "_b_empty"},  32'(b_empty),  1);
    chk({t, "_b_rvalid"}, 32'(b_rv),     0);
    chk({t, "_b_level"},  32'(b_level),  0);
    chk({t, "_b_rdata"},  32'(b_rdata),  0);
  endtask

  task automatic do_reset(input string t);
    resetn = 1'b0;
    #2;
    check_reset(t);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn, rn;
    do_reset("por");

    // Fill / drain, standard read
    for (int i = 0; i < 16; i++) begin
      a_op(8'(i), W);
      chk("fill_level", 32'(a_level), i + 1);
      chk("fill_afull", 32'(a_af), 32'((i + 1) >= 12));
      chk("fill_full", 32'(a_full), 32'(i == 15));
    end
    a_op(8'hFF, W);
    chk("ovf_level", 32'(a_level), 16);
    chk("ovf_flag", 32'(a_ovf), 1);
    chk("ovf_udf", 32'(a_udf), 0);
    a_op(8'hEE, W | R);
    chk("fullrw_rvalid", 32'(a_rv), 1);
    chk("fullrw_data", 32'(a_rdata), 'h00);
    chk("fullrw_level", 32'(a_level), 15);
    chk("fullrw_full", 32'(a_full), 1);
    for (int i = 1; i < 16; i++) begin
      a_op(8'h00, R);
      chk("drain_rvalid", 32'(a_rv), 1);
      chk("drain_data", 32'(a_rdata), i);
      chk("drain_level", 32'(a_level), 15 - i);
      chk("drain_aempty", 32'(a_ae), 32'((15 - i) <= 4));
    end
    chk("drain_empty", 32'(a_empty), 1);
    a_op(8'h00, NOP);
    chk("hold_rvalid", 32'(a_rv), 0);
    chk("hold_data", 32'(a_rdata), 'h0F);
    a_op(8'h00, R);
    chk("udf_flag", 32'(a_udf), 1);
    chk("udf_rvalid", 32'(a_rv), 0);
    chk("udf_level", 32'(a_level), 0);
    a_op(8'h00, R | CL);
    chk("clr_vs_err_udf", 32'(a_udf), 1);
    chk("clr_ovf", 32'(a_ovf), 0);
    a_op(8'h00, CL);
    chk("clr_udf", 32'(a_udf), 0);

    // FWFT latency and replay on instance b
    b_op(8'hA5, W);
    chk("fwft_k0_rvalid", 32'(b_rv), 0);
    chk("fwft_k0_empty", 32'(b_empty), 1);
    chk("fwft_k0_level", 32'(b_level), 1);
    b_op(8'h00, NOP);
    chk("fwft_k1_rvalid", 32'(b_rv), 0);
    b_op(8'h00, NOP);
    chk("fwft_k2_rvalid", 32'(b_rv), 1);
    chk("fwft_k2_data", 32'(b_rdata), 'hA5);
    chk("fwft_k2_empty", 32'(b_empty), 0);
    b_op(8'h00, R);
    chk("fwft_pop_empty", 32'(b_empty), 1);
    chk("fwft_pop_level", 32'(b_level), 0);
    chk("fwft_pop_udf", 32'(b_udf), 0);
    b_op(8'h00, M);
    b_op(8'hB0, W);
    b_op(8'hB1, W);
    b_op(8'hB2, W);
    b_op(8'h00, NOP);
    chk("fwft_head_rvalid", 32'(b_rv), 1);
    chk("fwft_head_data", 32'(b_rdata), 'hB0);
    chk("fwft_head_level", 32'(b_level), 3);
    for (int i = 1; i < 3; i++) begin
      b_op(8'h00, R);
      chk("fwft_b2b_rvalid", 32'(b_rv), 1);
      chk("fwft_b2b_data", 32'(b_rdata), 'hB0 + i);
      chk("fwft_b2b_level", 32'(b_level), 3 - i);
    end
    b_op(8'h00, R);
    chk("fwft_last_empty", 32'(b_empty), 1);
    b_op(8'h00, R | RW);
    chk("fwft_rew_rvalid", 32'(b_rv), 0);
    chk("fwft_rew_level", 32'(b_level), 3);
    chk("fwft_rew_udf", 32'(b_udf), 0);
    b_op(8'h00, NOP);
    chk("fwft_rew1_rvalid", 32'(b_rv), 0);
    b_op(8'h00, NOP);
    chk("fwft_rew2_rvalid", 32'(b_rv), 1);
    chk("fwft_rew2_data", 32'(b_rdata), 'hB0);

    // Replay on instance a
    do_reset("rep");
    for (int i = 0; i < 8; i++) a_op(8'(8'h10 + i), W);
    chk("rep_level", 32'(a_level), 8);
    a_op(8'h00, M);
    for (int i = 0; i < 8; i++) begin
      a_op(8'h00, R);
      chk("rep_read1", 32'(a_rdata), 'h10 + i);
    end
    chk("rep_empty", 32'(a_empty), 1);
    chk("rep_full", 32'(a_full), 0);
    a_op(8'h00, R | RW);
    chk("rdrew_udf", 32'(a_udf), 0);
    chk("rdrew_rvalid", 32'(a_rv), 0);
    chk("rdrew_level", 32'(a_level), 8);
    for (int i = 0; i < 3; i++) begin
      a_op(8'h00, R);
      chk("rep_read2", 32'(a_rdata), 'h10 + i);
    end
    a_op(8'h00, M | RW);
    chk("mkrew_level", 32'(a_level), 8);
    for (int i = 0; i < 8; i++) begin
      a_op(8'h00, R);
      chk("rep_read3", 32'(a_rdata), 'h10 + i);
    end
    a_op(8'h00, RW);
    chk("rew_level", 32'(a_level), 8);
    a_op(8'h00, R);
    chk("mark_kept", 32'(a_rdata), 'h10);
    chk("mark_kept_level", 32'(a_level), 7);
    for (int i = 0; i < 8; i++) begin
      a_op(8'(8'h18 + i), W);
      chk("prot_full", 32'(a_full), 32'(i == 7));
      chk("prot_afull", 32'(a_af), 32'(i >= 3));
      chk("prot_level", 32'(a_level), 8 + i);
    end

    // Pointer wrap with mark following each pop
    do_reset("wrap");
    wn = 0;
    rn = 0;
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 5; j++) begin
        a_op(8'('h40 + wn), W);
        wn++;
        chk("wrap_wlevel", 32'(a_level), j + 1);
        chk("wrap_aempty", 32'(a_ae), 32'((j + 1) <= 4));
      end
      chk("wrap_full", 32'(a_full), 0);
      for (int j = 0; j < 5; j++) begin
        a_op(8'h00, R | M);
        chk("wrap_data", 32'(a_rdata), 'h40 + rn);
        rn++;
        chk("wrap_rlevel", 32'(a_level), 4 - j);
      end
    end

    // Reset mid-stream
    a_op(8'h00, R);
    chk("mid_udf_set", 32'(a_udf), 1);
    for (int i = 0; i < 9; i++) a_op(8'(8'h80 + i), W);
    chk("mid_level", 32'(a_level), 9);
    do_reset("mid");
    a_op(8'h5A, W);
    chk("post_level", 32'(a_level), 1);
    a_op(8'h00, R);
    chk("post_rvalid", 32'(a_rv), 1);
    chk("post_data", 32'(a_rdata), 'h5A);
    chk("post_empty", 32'(a_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
